// File: rtl/dino_pkg.sv
// Shared types and constants for the runner-game obstacle scheduler.
package dino_pkg;

    localparam int              LFSR_W    = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

    typedef enum logic [1:0] {
        SMALL  = 2'd0,
        LARGE  = 2'd1,
        BIRD   = 2'd2,
        DOUBLE = 2'd3
    } spawn_type_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WAIT,
        SPAWN
    } sched_state_t;

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Spawn request channel from the scheduler to the obstacle renderer.
interface obstacle_scheduler_if;
    import dino_pkg::*;

    logic        spawn_valid;
    logic        spawn_ready;
    spawn_type_t spawn_type;
    logic [7:0]  spawn_count;

    modport master (
        output spawn_valid,
        output spawn_type,
        output spawn_count,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_type,
        input  spawn_count,
        output spawn_ready
    );

endinterface

// File: rtl/lfsr5.sv
// 5-bit pseudo-random source; a stuck-at-zero register is forced back to the seed.
module lfsr5
    import dino_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] value_q;
    logic [LFSR_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (value_q == '0) begin
            value_d = LFSR_SEED;
        end else if (step) begin
            value_d = {value_q[3:0], value_q[1] ^ value_q[4]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Draws obstacle type and frame gap from the LFSR, counts frame ticks and
// offers each spawn to the renderer; the minimum gap shrinks as spawns are accepted.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int MIN_GAP       = 24,
    parameter int MIN_GAP_FLOOR = 12,
    parameter int SPEEDUP_EVERY = 8,
    parameter int BIRD_AFTER    = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  run,
    input  logic                  jump,
    obstacle_scheduler_if.master  bus
);

    localparam logic [6:0] MIN_GAP_C    = 7'(MIN_GAP);
    localparam logic [6:0] FLOOR_C      = 7'(MIN_GAP_FLOOR);
    localparam logic [7:0] SPEEDUP_C    = 8'(SPEEDUP_EVERY);
    localparam logic [7:0] BIRD_AFTER_C = 8'(BIRD_AFTER);

    sched_state_t      state_q;
    logic              valid_q;
    spawn_type_t       type_q;
    logic [7:0]        count_q;
    logic [6:0]        cur_min_q;
    logic [6:0]        gap_q;

    logic [LFSR_W-1:0] rnd;
    logic              lfsr_step;
    logic [7:0]        count_inc;
    logic              speedup;
    logic [1:0]        draw_type;

    // Jump and a draw in the same cycle still advance the LFSR only once.
    assign lfsr_step = jump | (state_q == DRAW);

    lfsr5 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .value (rnd)
    );

    assign count_inc = (count_q == 8'd255) ? count_q : count_q + 8'd1;
    assign speedup   = (count_inc != 8'd0) && ((count_inc % SPEEDUP_C) == 8'd0)
                       && (cur_min_q > FLOOR_C);

    // Birds stay locked out until the player has cleared a few obstacles.
    always_comb begin
        draw_type = rnd[4:3];
        if ((draw_type == 2'd2) && (count_q < BIRD_AFTER_C)) begin
            draw_type = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            type_q    <= SMALL;
            count_q   <= 8'd0;
            cur_min_q <= MIN_GAP_C;
            gap_q     <= 7'd0;
        end else if ((state_q != IDLE) && !run) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q   <= DRAW;
                        count_q   <= 8'd0;
                        cur_min_q <= MIN_GAP_C;
                    end
                end
                DRAW: begin
                    type_q  <= spawn_type_t'(draw_type);
                    gap_q   <= cur_min_q + {2'b00, rnd};
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (gap_q == 7'd1) begin
                            state_q <= SPAWN;
                            valid_q <= 1'b1;
                        end else begin
                            gap_q <= gap_q - 7'd1;
                        end
                    end
                end
                SPAWN: begin
                    if (bus.spawn_ready) begin
                        count_q <= count_inc;
                        if (speedup) begin
                            cur_min_q <= cur_min_q - 7'd1;
                        end
                        valid_q <= 1'b0;
                        state_q <= DRAW;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spawn_valid = valid_q;
    assign bus.spawn_type  = type_q;
    assign bus.spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench: directed scenarios plus randomized runs against a spawn-level reference model.
module tb_obstacle_scheduler;
    import dino_pkg::*;

    localparam int MIN_GAP       = 24;
    localparam int MIN_GAP_FLOOR = 12;
    localparam int SPEEDUP_EVERY = 8;
    localparam int BIRD_AFTER    = 4;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic run;
    logic jump;

    obstacle_scheduler_if sif ();

    obstacle_scheduler #(
        .MIN_GAP       (MIN_GAP),
        .MIN_GAP_FLOOR (MIN_GAP_FLOOR),
        .SPEEDUP_EVERY (SPEEDUP_EVERY),
        .BIRD_AFTER    (BIRD_AFTER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .run        (run),
        .jump       (jump),
        .bus        (sif)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: what the game has promised so far, tracked per spawn.
    logic [4:0] mLfsr;
    bit         mInGame;
    bit         mDrawNow;
    bit         mPending;
    logic [1:0] mType;
    int         mCount;
    int         mFrames;

    task automatic cycle();
        logic [4:0] rnd;
        logic [1:0] t;
        int         minGap;
        bit         stepNow;
        @(posedge clk);
        if (!reset) begin
            mLfsr    = 5'b00001;
            mInGame  = 0;
            mDrawNow = 0;
            mPending = 0;
            mType    = 2'd0;
            mCount   = 0;
            mFrames  = 0;
        end else begin
            stepNow = jump || mDrawNow;
            rnd     = mLfsr;
            if (!mInGame) begin
                if (run) begin
                    mInGame  = 1;
                    mDrawNow = 1;
                    mCount   = 0;
                end
            end else if (!run) begin
                mInGame  = 0;
                mDrawNow = 0;
                mPending = 0;
            end else if (mDrawNow) begin
                t = rnd[4:3];
                if (t == 2'd2 && mCount < BIRD_AFTER) t = 2'd0;
                mType  = t;
                minGap = MIN_GAP - mCount / SPEEDUP_EVERY;
                if (minGap < MIN_GAP_FLOOR) minGap = MIN_GAP_FLOOR;
                mFrames  = minGap + int'(rnd);
                mDrawNow = 0;
            end else if (mPending) begin
                if (sif.spawn_ready) begin
                    if (mCount < 255) mCount++;
                    mPending = 0;
                    mDrawNow = 1;
                end
            end else if (frame_tick) begin
                mFrames--;
                if (mFrames == 0) mPending = 1;
            end
            if (stepNow) mLfsr = {mLfsr[3:0], mLfsr[1] ^ mLfsr[4]};
        end
        #1;
    endtask

    // Counts cycles, ticking every frame, until a spawn is offered (bounded).
    task automatic wait_frames(output int n);
        frame_tick = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sif.spawn_valid && n < 300);
        frame_tick = 1'b0;
    endtask

    task automatic accept();
        sif.spawn_ready = 1'b1;
        cycle();
        sif.spawn_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; jump = 1'b0; frame_tick = 1'b0; sif.spawn_ready = 1'b0;
        cycle();
        cycle();
        nTests++;
        if (sif.spawn_valid !== 1'b0) begin
            nFail++; $display("[TB] FAIL reset_valid: got %0b expected 0", sif.spawn_valid);
        end
        nTests++;
        if (sif.spawn_type !== SMALL) begin
            nFail++; $display("[TB] FAIL reset_type: got %0d expected 0", sif.spawn_type);
        end
        nTests++;
        if (sif.spawn_count !== 8'd0) begin
            nFail++; $display("[TB] FAIL reset_count: got %0d expected 0", sif.spawn_count);
        end
        reset = 1'b1;
        repeat (3) cycle();
        nTests++;
        if (sif.spawn_valid !== 1'b0) begin
            nFail++; $display("[TB] FAIL idle_valid: got %0b expected 0", sif.spawn_valid);
        end
    endtask

    task automatic test_first_draws();
        int n;
        reset = 1'b0; cycle(); reset = 1'b1;
        run = 1'b1;
        cycle();
        wait_frames(n);
        nTests++;
        if (n != 26) begin
            nFail++; $display("[TB] FAIL first_gap: got %0d cycles expected 26", n);
        end
        nTests++;
        if (sif.spawn_type !== SMALL) begin
            nFail++; $display("[TB] FAIL first_type: got %0d expected 0", sif.spawn_type);
        end
        accept();
        nTests++;
        if (sif.spawn_count !== 8'd1 || sif.spawn_valid !== 1'b0) begin
            nFail++; $display("[TB] FAIL first_accept: got count=%0d valid=%0b expected count=1 valid=0",
                              sif.spawn_count, sif.spawn_valid);
        end
        wait_frames(n);
        nTests++;
        if (n != 27) begin
            nFail++; $display("[TB] FAIL second_gap: got %0d cycles expected 27", n);
        end
        accept();
    endtask

    task automatic test_bird_mask_backpressure();
        int n;
        run = 1'b0;
        reset = 1'b0; cycle(); reset = 1'b1;
        jump = 1'b1;
        repeat (4) cycle();
        jump = 1'b0;
        run = 1'b1;
        cycle();
        wait_frames(n);
        nTests++;
        if (n != 46) begin
            nFail++; $display("[TB] FAIL bird_gap: got %0d cycles expected 46", n);
        end
        nTests++;
        if (sif.spawn_type !== SMALL) begin
            nFail++; $display("[TB] FAIL bird_mask: got type %0d expected 0", sif.spawn_type);
        end
        frame_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            nTests++;
            if (sif.spawn_valid !== 1'b1 || sif.spawn_type !== SMALL || sif.spawn_count !== 8'd0) begin
                nFail++; $display("[TB] FAIL backpressure_hold %0d: got valid=%0b type=%0d count=%0d expected 1/0/0",
                                  i, sif.spawn_valid, sif.spawn_type, sif.spawn_count);
            end
        end
        frame_tick = 1'b0;
        accept();
        nTests++;
        if (sif.spawn_count !== 8'd1 || sif.spawn_valid !== 1'b0) begin
            nFail++; $display("[TB] FAIL backpressure_accept: got count=%0d valid=%0b expected 1/0",
                              sif.spawn_count, sif.spawn_valid);
        end
    endtask

    task automatic test_jump_in_draw();
        int n;
        run = 1'b0;
        reset = 1'b0; cycle(); reset = 1'b1;
        run = 1'b1;
        cycle();
        jump = 1'b1;
        cycle();
        jump = 1'b0;
        wait_frames(n);
        nTests++;
        if (n != 25) begin
            nFail++; $display("[TB] FAIL jump_draw_gap: got %0d cycles expected 25", n);
        end
        accept();
        // A double step in the draw cycle would yield rnd=5 here instead of 2.
        wait_frames(n);
        nTests++;
        if (n != 27) begin
            nFail++; $display("[TB] FAIL jump_single_step: got %0d cycles expected 27", n);
        end
    endtask

    task automatic test_abort();
        int n;
        run = 1'b0;
        sif.spawn_ready = 1'b1;
        cycle();
        sif.spawn_ready = 1'b0;
        nTests++;
        if (sif.spawn_valid !== 1'b0 || sif.spawn_count !== 8'd1) begin
            nFail++; $display("[TB] FAIL abort: got valid=%0b count=%0d expected 0/1",
                              sif.spawn_valid, sif.spawn_count);
        end
        run = 1'b1;
        cycle();
        nTests++;
        if (sif.spawn_count !== 8'd0) begin
            nFail++; $display("[TB] FAIL new_game_count: got %0d expected 0", sif.spawn_count);
        end
        wait_frames(n);
        nTests++;
        if (n != 30) begin
            nFail++; $display("[TB] FAIL lfsr_kept: got %0d cycles expected 30", n);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        accept();
        frame_tick = 1'b1;
        repeat (5) cycle();
        frame_tick = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        nTests++;
        if (sif.spawn_valid !== 1'b0 || sif.spawn_type !== SMALL || sif.spawn_count !== 8'd0) begin
            nFail++; $display("[TB] FAIL mid_wait_reset: got valid=%0b type=%0d count=%0d expected 0/0/0",
                              sif.spawn_valid, sif.spawn_type, sif.spawn_count);
        end
        cycle();
        wait_frames(n);
        nTests++;
        if (n != 26) begin
            nFail++; $display("[TB] FAIL lfsr_reseed: got %0d cycles expected 26", n);
        end
    endtask

    task automatic test_random();
        run = 1'b0; jump = 1'b0; frame_tick = 1'b0; sif.spawn_ready = 1'b0;
        reset = 1'b0; cycle(); reset = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(0, 999) != 0);
            run             = ($urandom_range(0, 1499) != 0);
            jump            = ($urandom_range(0, 3) == 0);
            frame_tick      = $urandom_range(0, 1) == 1;
            sif.spawn_ready = ($urandom_range(0, 2) != 0);
            cycle();
            nTests++;
            if ({sif.spawn_valid, sif.spawn_type, sif.spawn_count} !== {mPending, mType, 8'(mCount)}) begin
                nFail++; $display("[TB] FAIL random cycle %0d: got v=%0b t=%0d c=%0d expected v=%0b t=%0d c=%0d",
                                  i, sif.spawn_valid, sif.spawn_type, sif.spawn_count, mPending, mType, mCount);
            end
        end
    endtask

    task automatic test_saturation();
        int extra = 0;
        run = 1'b0; jump = 1'b0;
        reset = 1'b0; cycle(); reset = 1'b1;
        run = 1'b1; frame_tick = 1'b1; sif.spawn_ready = 1'b1;
        for (int i = 0; i < 20000 && extra < 300; i++) begin
            jump = ($urandom_range(0, 7) == 0);
            cycle();
            nTests++;
            if ({sif.spawn_valid, sif.spawn_type, sif.spawn_count} !== {mPending, mType, 8'(mCount)}) begin
                nFail++; $display("[TB] FAIL saturation cycle %0d: got v=%0b t=%0d c=%0d expected v=%0b t=%0d c=%0d",
                                  i, sif.spawn_valid, sif.spawn_type, sif.spawn_count, mPending, mType, mCount);
            end
            if (mCount == 255) extra++;
        end
        nTests++;
        if (sif.spawn_count !== 8'd255) begin
            nFail++; $display("[TB] FAIL count_saturate: got %0d expected 255", sif.spawn_count);
        end
        run = 1'b0; frame_tick = 1'b0; sif.spawn_ready = 1'b0; jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_draws();
        test_bird_mask_backpressure();
        test_jump_in_draw();
        test_abort();
        test_reset_mid_wait();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
